// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// Grants one owner per burst of up to MAX_BURST beats and honours FIFO back-pressure.
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*DATA_WIDTH-1:0]   wr_data,
  output logic [N_REQ-1:0]              gnt,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          fifo_full,
  output logic                          busy,
  output logic [$clog2(N_REQ)-1:0]      owner
);

  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg;
  logic [OW-1:0]   owner_reg;
  logic [OW-1:0]   last_owner_reg;
  logic [CW-1:0]   beat_cnt_reg;

  logic [OW-1:0]   sel_next;
  logic [CW-1:0]   beat_cnt_next;
  logic            accept;
  int              scan_idx;
  logic            found;

  logic [DATA_WIDTH-1:0] slice [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign slice[gi] = wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign gnt[gi]   = accept && (owner_reg == OW'(gi));
    end
  endgenerate

  // First requester after last_owner, wrapping modulo N_REQ.
  always_comb begin
    found    = 1'b0;
    sel_next = '0;
    scan_idx = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = (int'(last_owner_reg) + k) % N_REQ;
      if (!found && req[OW'(scan_idx)]) begin
        found    = 1'b1;
        sel_next = OW'(scan_idx);
      end
    end
  end

  // Reset masks the outputs immediately so an aborted burst never pushes.
  assign accept        = (state_reg == GRANT) && req[owner_reg] && !fifo_full && !rst;
  assign fifo_push     = accept;
  assign fifo_wdata    = accept ? slice[owner_reg] : '0;
  assign busy          = (state_reg == GRANT) && !rst;
  assign owner         = owner_reg;
  assign beat_cnt_next = beat_cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_owner_reg <= OW'(N_REQ - 1);
      beat_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found && !fifo_full) begin
            state_reg    <= GRANT;
            owner_reg    <= sel_next;
            beat_cnt_reg <= '0;
          end
        end
        GRANT: begin
          if (!req[owner_reg]) begin
            state_reg      <= IDLE;
            last_owner_reg <= owner_reg;
          end else if (!fifo_full) begin
            beat_cnt_reg <= beat_cnt_next;
            if (beat_cnt_next == CW'(MAX_BURST)) begin
              state_reg      <= IDLE;
              last_owner_reg <= owner_reg;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: scenario tasks with a push scoreboard
// that compares each FIFO write against the expected requester and data.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [31:0] wr_data;
  logic        fifo_full = 1'b0;
  logic [3:0]  gnt;
  logic        fifo_push;
  logic [7:0]  fifo_wdata;
  logic        busy;
  logic [1:0]  owner;

  logic [7:0]  data_val [4];
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } beat_t;
  beat_t exp_q[$];

  fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .wr_data(wr_data), .gnt(gnt),
    .fifo_push(fifo_push), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < 4; i++) wr_data[i*8 +: 8] = data_val[i];
  end

  function automatic void push_exp(input logic [1:0] i, input logic [7:0] d);
    beat_t b;
    b.idx  = i;
    b.data = d;
    exp_q.push_back(b);
  endfunction

  // Scoreboard and invariants, sampled on the falling edge.
  always @(negedge clk) begin
    beat_t b;
    if (mon_en) begin
      total++;
      if (!$onehot0(gnt)) begin
        bad++;
        $display("FAIL gnt_onehot: gnt=%b required zero or one-hot", gnt);
      end
      total++;
      if (fifo_push !== (|gnt)) begin
        bad++;
        $display("FAIL push_eq_gnt: fifo_push=%b required %b", fifo_push, |gnt);
      end
      total++;
      if (fifo_full && fifo_push) begin
        bad++;
        $display("FAIL push_when_full: fifo_push=%b required 0", fifo_push);
      end
      if (fifo_push) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_push: gnt=%b data=%h required no push", gnt, fifo_wdata);
        end else begin
          b = exp_q.pop_front();
          if (fifo_wdata !== b.data || gnt !== (4'b0001 << b.idx)) begin
            bad++;
            $display("FAIL push_beat: gnt=%b data=%h required gnt=%b data=%h",
                     gnt, fifo_wdata, 4'b0001 << b.idx, b.data);
          end else begin
            $display("push req=%0d data=%h", b.idx, fifo_wdata);
          end
        end
      end
    end
  end

  // Finish the current cycle; producers advance data after a granted beat.
  task automatic tick();
    logic [3:0] g;
    g = gnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (g[i]) data_val[i] = data_val[i] + 8'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) data_val[i] = 8'h50 + 8'(i);
    rst = 1'b1;
    req = 4'b1111;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (gnt !== 4'b0000 || fifo_push !== 1'b0 || busy !== 1'b0 || owner !== 2'd0) begin
        bad++;
        $display("FAIL reset_outputs: gnt=%b push=%b busy=%b owner=%0d required 0/0/0/0",
                 gnt, fifo_push, busy, owner);
      end
      tick();
    end
    mon_en = 1'b1;
    rst = 1'b0;
    push_exp(2'd0, 8'h50);
    @(negedge clk);
    total++;
    if (fifo_push !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_arb_cycle: push=%b busy=%b required 0/0", fifo_push, busy);
    end
    tick();
    @(negedge clk);
    total++;
    if (gnt !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_grant: gnt=%b owner=%0d busy=%b required 0001/0/1", gnt, owner, busy);
    end
    tick();
    req = 4'b0000;
    @(negedge clk);
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL reset_queue: pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_single();
    logic [9:0] pat;
    pat = 10'b0111101111;
    do_reset();
    data_val[2] = 8'h10;
    for (int k = 0; k < 8; k++) push_exp(2'd2, 8'h10 + 8'(k));
    req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (fifo_push !== pat[9-c]) begin
        bad++;
        $display("FAIL single_push c=%0d: push=%b required %b", c, fifo_push, pat[9-c]);
      end
      if (c > 0) begin
        total++;
        if (owner !== 2'd2) begin
          bad++;
          $display("FAIL single_owner c=%0d: owner=%0d required 2", c, owner);
        end
      end
      tick();
    end
    req = 4'b0000;
    @(negedge clk);
    total++;
    if (fifo_push !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_end: push=%b busy=%b required 0/0", fifo_push, busy);
    end
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_queue: pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_contention();
    logic [1:0] o;
    do_reset();
    for (int i = 0; i < 4; i++) data_val[i] = 8'(i * 32);
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < 4; k++) push_exp(2'(b % 4), 8'((b % 4) * 32 + (b / 4) * 4 + k));
    req = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      total++;
      if (fifo_push !== ((c % 5) != 0)) begin
        bad++;
        $display("FAIL contention_push c=%0d: push=%b required %b", c, fifo_push, (c % 5) != 0);
      end
      if ((c % 5) != 0) begin
        o = 2'(((c - 1) / 5) % 4);
        total++;
        if (owner !== o) begin
          bad++;
          $display("FAIL contention_owner c=%0d: owner=%0d required %0d", c, owner, o);
        end
      end
      tick();
    end
    req = 4'b0000;
    @(negedge clk);
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL contention_queue: pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0] full_pat;
    logic [7:0] push_pat;
    full_pat = 8'b00011100;
    push_pat = 8'b01100011;
    do_reset();
    data_val[1] = 8'hA0;
    for (int k = 0; k < 4; k++) push_exp(2'd1, 8'hA0 + 8'(k));
    req = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      fifo_full = full_pat[7-c];
      @(negedge clk);
      total++;
      if (fifo_push !== push_pat[7-c]) begin
        bad++;
        $display("FAIL bp_push c=%0d: push=%b required %b", c, fifo_push, push_pat[7-c]);
      end
      if (full_pat[7-c]) begin
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b1) begin
          bad++;
          $display("FAIL bp_stall c=%0d: gnt=%b busy=%b required 0000/1", c, gnt, busy);
        end
      end
      tick();
    end
    req = 4'b0000;
    fifo_full = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || fifo_push !== 1'b0) begin
      bad++;
      $display("FAIL bp_burst_len: busy=%b push=%b required 0/0", busy, fifo_push);
    end
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_queue: pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_early_release();
    logic [3:0] rq [7];
    logic [6:0] push_pat;
    logic [6:0] busy_pat;
    rq = '{4'b1000, 4'b1001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    push_pat = 7'b0100100;
    busy_pat = 7'b0110110;
    do_reset();
    data_val[3] = 8'hC0;
    data_val[0] = 8'h01;
    push_exp(2'd3, 8'hC0);
    push_exp(2'd0, 8'h01);
    for (int c = 0; c < 7; c++) begin
      req = rq[c];
      @(negedge clk);
      total++;
      if (fifo_push !== push_pat[6-c] || busy !== busy_pat[6-c]) begin
        bad++;
        $display("FAIL early_cycle c=%0d: push=%b busy=%b required %b/%b",
                 c, fifo_push, busy, push_pat[6-c], busy_pat[6-c]);
      end
      if (c == 2 || c == 4) begin
        total++;
        if (owner !== ((c == 2) ? 2'd3 : 2'd0)) begin
          bad++;
          $display("FAIL early_owner c=%0d: owner=%0d required %0d", c, owner, (c == 2) ? 3 : 0);
        end
      end
      tick();
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL early_queue: pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] rq [7];
    logic [6:0] rst_pat;
    logic [6:0] push_pat;
    logic [6:0] busy_pat;
    rq = '{4'b0100, 4'b0100, 4'b0100, 4'b0101, 4'b0101, 4'b0000, 4'b0000};
    rst_pat  = 7'b0010000;
    push_pat = 7'b0100100;
    busy_pat = 7'b0100110;
    do_reset();
    data_val[2] = 8'h30;
    data_val[0] = 8'h70;
    push_exp(2'd2, 8'h30);
    push_exp(2'd0, 8'h70);
    for (int c = 0; c < 7; c++) begin
      req = rq[c];
      rst = rst_pat[6-c];
      @(negedge clk);
      total++;
      if (fifo_push !== push_pat[6-c] || busy !== busy_pat[6-c]) begin
        bad++;
        $display("FAIL rstmid_cycle c=%0d: push=%b busy=%b required %b/%b",
                 c, fifo_push, busy, push_pat[6-c], busy_pat[6-c]);
      end
      if (c == 2) begin
        total++;
        if (gnt !== 4'b0000 || fifo_wdata !== 8'h00) begin
          bad++;
          $display("FAIL rstmid_abort: gnt=%b data=%h required 0000/00", gnt, fifo_wdata);
        end
      end
      tick();
    end
    rst = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rstmid_queue: pending=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) data_val[i] = 8'h00;
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_early_release();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
